// File: rtl/hash_driver.sv
// rtl/hash_driver.sv - Avalon-MM master sequencing one SHA-256 accelerator transaction per start.
module hash_driver #(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [31:0]  msg_w0,
    input  logic [31:0]  msg_w1,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [255:0] digest,
    output logic [3:0]   m_address,
    output logic         m_read,
    output logic         m_write,
    output logic [31:0]  m_writedata,
    input  logic [31:0]  m_readdata,
    input  logic         m_waitrequest
);

    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_W0,
        WR_W1,
        WR_GO,
        RD_REQ,
        RD_WAIT,
        FIN
    } state_t;

    state_t             state, state_n;
    logic [31:0]        w1;
    logic [2:0]         idx;
    logic [2:0]         lat_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [31:0]        shadow [8];

    logic        m_read_n, m_write_n, busy_n, done_n, error_n;
    logic [3:0]  m_address_n;
    logic [31:0] m_writedata_n;

    logic cmd_active, accepted, stalled, timeout, capture;

    assign cmd_active = m_read | m_write;
    assign accepted   = cmd_active & ~m_waitrequest;
    assign stalled    = cmd_active & m_waitrequest;
    assign timeout    = stalled && (stall_cnt == STALL_LAST);
    assign capture    = (state == RD_WAIT) && (lat_cnt == 3'd1);

    // Bus outputs are registered: next values are computed here alongside the next state.
    always_comb begin
        state_n       = state;
        m_read_n      = m_read;
        m_write_n     = m_write;
        m_address_n   = m_address;
        m_writedata_n = m_writedata;
        busy_n        = busy;
        done_n        = 1'b0;
        error_n       = 1'b0;
        if (timeout) begin
            state_n       = IDLE;
            m_read_n      = 1'b0;
            m_write_n     = 1'b0;
            m_address_n   = 4'd0;
            m_writedata_n = 32'd0;
            busy_n        = 1'b0;
            error_n       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n       = WR_W0;
                        m_write_n     = 1'b1;
                        m_address_n   = 4'd1;
                        m_writedata_n = msg_w0;
                        busy_n        = 1'b1;
                    end
                end
                WR_W0: begin
                    if (accepted) begin
                        state_n       = WR_W1;
                        m_address_n   = 4'd2;
                        m_writedata_n = w1;
                    end
                end
                WR_W1: begin
                    if (accepted) begin
                        state_n       = WR_GO;
                        m_address_n   = 4'd0;
                        m_writedata_n = 32'd0;
                    end
                end
                WR_GO: begin
                    if (accepted) begin
                        state_n     = RD_REQ;
                        m_write_n   = 1'b0;
                        m_read_n    = 1'b1;
                        m_address_n = 4'd3;
                    end
                end
                RD_REQ: begin
                    if (accepted) begin
                        state_n  = RD_WAIT;
                        m_read_n = 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        if (idx == 3'd7) begin
                            state_n = FIN;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end else begin
                            state_n     = RD_REQ;
                            m_read_n    = 1'b1;
                            m_address_n = 4'd3 + {1'b0, idx + 3'd1};
                        end
                    end
                end
                FIN:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= 4'd0;
            m_writedata <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            m_read      <= m_read_n;
            m_write     <= m_write_n;
            m_address   <= m_address_n;
            m_writedata <= m_writedata_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    // Words collect in shadow; digest only changes when the eighth word lands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w1        <= 32'd0;
            idx       <= 3'd0;
            lat_cnt   <= 3'd0;
            stall_cnt <= '0;
            digest    <= 256'd0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 32'd0;
            end
        end else begin
            stall_cnt <= (stalled && !timeout) ? stall_cnt + STALL_W'(1) : '0;
            if (state == IDLE && start) begin
                w1 <= msg_w1;
            end
            if (state == WR_GO && accepted) begin
                idx <= 3'd0;
            end
            if (state == RD_REQ && accepted && !timeout) begin
                lat_cnt <= 3'(READ_LATENCY);
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                shadow[idx] <= m_readdata;
                if (idx == 3'd7) begin
                    digest <= {shadow[0], shadow[1], shadow[2], shadow[3],
                               shadow[4], shadow[5], shadow[6], m_readdata};
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hash_driver.sv
// tb/tb_hash_driver.sv - directed bench for hash_driver at read latency 1 and 3.
module tb_hash_driver;

    localparam logic [255:0] EXP = 256'h5D030303_5E040404_5F050505_60060606_61070707_62080808_63090909_640A0A0A;
    localparam logic [31:0]  POISON = 32'hBAD0BAD0;

    logic         clock, resetn;
    logic         a_start, a_busy, a_done, a_error, a_m_read, a_m_write, a_wait;
    logic [31:0]  a_w0, a_w1, a_m_writedata, a_rdata;
    logic [3:0]   a_m_address;
    logic [255:0] a_digest;
    logic         b_start, b_busy, b_done, b_error, b_m_read, b_m_write, b_wait;
    logic [31:0]  b_w0, b_w1, b_m_writedata, b_rdata;
    logic [3:0]   b_m_address;
    logic [255:0] b_digest;

    int vectors = 0;
    int miscompares = 0;

    hash_driver #(.READ_LATENCY(1), .TIMEOUT_CYCLES(1023)) dut_a (
        .clock(clock), .resetn(resetn), .start(a_start), .msg_w0(a_w0), .msg_w1(a_w1),
        .busy(a_busy), .done(a_done), .error(a_error), .digest(a_digest),
        .m_address(a_m_address), .m_read(a_m_read), .m_write(a_m_write),
        .m_writedata(a_m_writedata), .m_readdata(a_rdata), .m_waitrequest(a_wait)
    );

    hash_driver #(.READ_LATENCY(3), .TIMEOUT_CYCLES(16)) dut_b (
        .clock(clock), .resetn(resetn), .start(b_start), .msg_w0(b_w0), .msg_w1(b_w1),
        .busy(b_busy), .done(b_done), .error(b_error), .digest(b_digest),
        .m_address(b_m_address), .m_read(b_m_read), .m_write(b_m_write),
        .m_writedata(b_m_writedata), .m_readdata(b_rdata), .m_waitrequest(b_wait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] slave_word(input logic [3:0] a);
        return 32'h5A00_0000 + 32'h0101_0101 * {28'd0, a};
    endfunction

    // Slave models: read data is valid only in the single cycle ending at the capture edge.
    logic [2:0] a_rcnt, b_rcnt;
    logic [3:0] a_raddr, b_raddr;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_rcnt <= 3'd0; a_raddr <= 4'd0; b_rcnt <= 3'd0; b_raddr <= 4'd0;
        end else begin
            if (a_m_read && !a_wait) begin a_rcnt <= 3'd1; a_raddr <= a_m_address; end
            else if (a_rcnt != 3'd0) a_rcnt <= a_rcnt - 3'd1;
            if (b_m_read && !b_wait) begin b_rcnt <= 3'd3; b_raddr <= b_m_address; end
            else if (b_rcnt != 3'd0) b_rcnt <= b_rcnt - 3'd1;
        end
    end
    assign a_rdata = (a_rcnt == 3'd1) ? slave_word(a_raddr) : POISON;
    assign b_rdata = (b_rcnt == 3'd1) ? slave_word(b_raddr) : POISON;

    logic [35:0] a_wlog[$];
    logic [3:0]  a_rlog[$], b_rlog[$];
    int a_done_cnt = 0, a_err_cnt = 0, b_done_cnt = 0, b_err_cnt = 0;
    always @(posedge clock) begin
        if (a_m_write && !a_wait) a_wlog.push_back({a_m_address, a_m_writedata});
        if (a_m_read && !a_wait)  a_rlog.push_back(a_m_address);
        if (b_m_read && !b_wait)  b_rlog.push_back(b_m_address);
        if (a_done)  a_done_cnt++;
        if (a_error) a_err_cnt++;
        if (b_done)  b_done_cnt++;
        if (b_error) b_err_cnt++;
    end

    function automatic logic [115:0] pack_w(input logic [35:0] q[$]);
        logic [107:0] v = '0;
        for (int i = 0; i < q.size() && i < 3; i++) v = {v[71:0], q[i]};
        return {8'(q.size()), v};
    endfunction

    function automatic logic [39:0] pack_r(input logic [3:0] q[$]);
        logic [31:0] v = '0;
        for (int i = 0; i < q.size() && i < 8; i++) v = {v[27:0], q[i]};
        return {8'(q.size()), v};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_go(input logic [31:0] w0, input logic [31:0] w1);
        a_w0 = w0; a_w1 = w1; a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
    endtask

    task automatic b_go(input logic [31:0] w0, input logic [31:0] w1);
        b_w0 = w0; b_w1 = w1; b_start = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
    endtask

    task automatic a_wait_read(input string tag, input logic [3:0] addr);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (a_m_read && a_m_address == addr) found = 1'b1;
            else @(negedge clock);
        end
        check(tag, found, 1);
    endtask

    task automatic a_finish(input string tag, input bit poke_start);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (a_done) found = 1'b1;
        end
        check({tag, "_done"}, found, 1);
        check({tag, "_digest"}, {a_busy, a_digest}, {1'b0, EXP});
        if (poke_start) begin a_w0 = 32'h77777777; a_start = 1'b1; end
        @(negedge clock);
        a_start = 1'b0;
        check({tag, "_after"}, {a_done, a_busy, a_m_write, a_m_read}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, stable;
        int errk;
        resetn = 1'b0;
        a_start = 1'b0; a_w0 = '0; a_w1 = '0; a_wait = 1'b0;
        b_start = 1'b0; b_w0 = '0; b_w1 = '0; b_wait = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_a", {a_busy, a_done, a_error, a_m_read, a_m_write, a_m_address, a_m_writedata, a_digest}, 0);
        check("reset_b", {b_busy, b_done, b_error, b_m_read, b_m_write, b_m_address, b_m_writedata, b_digest}, 0);
        resetn = 1'b1;
        @(negedge clock);

        // basic run with 40-cycle stall on the first read
        a_wlog.delete(); a_rlog.delete();
        a_go(32'h61626380, 32'h0);
        check("first_cmd", {a_busy, a_m_write, a_m_read, a_m_address, a_m_writedata},
              {1'b1, 1'b1, 1'b0, 4'd1, 32'h61626380});
        a_wait_read("first_read", 4'd3);
        a_wait = 1'b1; stable = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (!(a_m_read && !a_m_write && a_m_address == 4'd3)) stable = 1'b0;
        end
        check("read_stall_hold", stable, 1);
        a_wait = 1'b0;
        a_finish("basic", 1'b0);
        check("basic_writes", pack_w(a_wlog), {8'd3, 4'd1, 32'h61626380, 4'd2, 32'h0, 4'd0, 32'h0});
        check("basic_reads", pack_r(a_rlog), {8'd8, 32'h3456789A});
        check("basic_done_count", a_done_cnt, 1);

        // 5-cycle stall on the WR_W1 write; start poked during FIN must be ignored
        a_go(32'h11111111, 32'h22222222);
        @(negedge clock);
        check("w1_cmd", {a_m_write, a_m_address, a_m_writedata}, {1'b1, 4'd2, 32'h22222222});
        a_wait = 1'b1; stable = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (!(a_m_write && !a_m_read && a_m_address == 4'd2 && a_m_writedata == 32'h22222222)) stable = 1'b0;
        end
        check("write_stall_hold", stable, 1);
        a_wait = 1'b0;
        @(negedge clock);
        check("go_after_accept", {a_m_write, a_m_address, a_m_writedata}, {1'b1, 4'd0, 32'h0});
        a_finish("stall", 1'b1);

        // start while busy
        a_wlog.delete();
        a_go(32'hAAAA0001, 32'h0);
        a_wait_read("busy_read", 4'd5);
        a_w0 = 32'hDEADBEEF; a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
        a_finish("busy", 1'b0);
        check("busy_writes", pack_w(a_wlog), {8'd3, 4'd1, 32'hAAAA0001, 4'd2, 32'h0, 4'd0, 32'h0});
        check("busy_done_count", a_done_cnt, 3);

        // next run carries only its own word, then async reset at the addr-6 read
        a_wlog.delete();
        a_go(32'hCAFEF00D, 32'h0);
        a_wait_read("reset_read", 4'd6);
        check("next_run_writes", pack_w(a_wlog), {8'd3, 4'd1, 32'hCAFEF00D, 4'd2, 32'h0, 4'd0, 32'h0});
        #2 resetn = 1'b0;
        #1 check("async_reset", {a_busy, a_done, a_error, a_m_read, a_m_write, a_m_address, a_m_writedata, a_digest}, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_reset_idle", {a_busy, a_m_read, a_m_write}, 0);
        a_wlog.delete(); a_rlog.delete();
        a_go(32'h12345678, 32'h9ABCDEF0);
        a_finish("recover", 1'b0);
        check("recover_writes", pack_w(a_wlog), {8'd3, 4'd1, 32'h12345678, 4'd2, 32'h9ABCDEF0, 4'd0, 32'h0});
        check("recover_reads", pack_r(a_rlog), {8'd8, 32'h3456789A});
        check("a_counts", {a_done_cnt, a_err_cnt}, {32'd4, 32'd0});

        // read latency 3 with poison outside the capture cycle
        b_rlog.delete();
        b_go(32'h01020304, 32'h05060708);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (b_done) found = 1'b1;
        end
        check("lat3_done", found, 1);
        check("lat3_digest", {b_busy, b_digest}, {1'b0, EXP});
        check("lat3_reads", pack_r(b_rlog), {8'd8, 32'h3456789A});
        @(negedge clock);

        // timeout with waitrequest stuck at the first read
        b_go(32'h0BADF00D, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (b_m_read) found = 1'b1;
            else @(negedge clock);
        end
        check("timeout_read_seen", found, 1);
        b_wait = 1'b1; errk = 0;
        for (int k = 1; k <= 40 && errk == 0; k++) begin
            @(negedge clock);
            if (b_error) errk = k;
        end
        check("timeout_cycles", errk, 16);
        check("timeout_outputs", {b_m_read, b_m_write, b_busy, b_done}, 0);
        check("timeout_digest_kept", b_digest, EXP);
        @(negedge clock);
        check("error_one_pulse", b_error, 0);
        b_wait = 1'b0;
        repeat (20) @(negedge clock);
        check("b_counts", {b_done_cnt, b_err_cnt}, {32'd1, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
